// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   Oversampling UART receiver. Deserialises the RX line (start bit,
//   DATA_WIDTH data bits LSB first, optional parity bit, one stop bit) into
//   a parallel byte. For each frame it raises one of three one-cycle
//   pulses: data_valid, par_err or stp_err.
//
// Ports
//   CLK        oversampling clock, Prescale cycles per bit
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high, already synchronised to CLK
//   Prescale   oversampling ratio (8, 16 or 32), captured at start detection
//   PAR_EN     1 = a parity bit follows the data, captured at start detection
//   PAR_TYP    0 = even parity, 1 = odd parity, captured at start detection
//   P_DATA     last correctly received byte; holds between good frames
//   data_valid one-cycle pulse, P_DATA has just been updated
//   par_err    one-cycle pulse, the frame's parity bit did not match
//   stp_err    one-cycle pulse, the stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;

    logic [PRESCALE_WIDTH-1:0] edge_cnt_reg;
    logic [BCW-1:0]            bit_cnt_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_reg;
    logic                      par_en_reg;
    logic                      par_typ_reg;
    logic [2:0]                samples_reg;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_flag_reg;
    logic [DATA_WIDTH-1:0]     p_data_reg;
    logic                      data_valid_reg;
    logic                      par_err_reg;
    logic                      stp_err_reg;

    // Decoded per-cycle strobes
    logic                      start_det;
    logic                      wrap;
    logic                      last_bit;
    logic                      majority;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      shift_en;
    logic                      par_chk;
    logic                      data_valid_next;
    logic                      par_err_next;
    logic                      stp_err_next;

    // The IDLE cycle that sees the falling edge is edge 0 of the start bit.
    assign start_det = (state_reg == IDLE) && !RX_IN;
    assign wrap      = (state_reg != IDLE) &&
                       (edge_cnt_reg == prescale_reg - PRESCALE_WIDTH'(1));
    assign last_bit  = (bit_cnt_reg == BCW'(DATA_WIDTH - 1));
    assign half      = prescale_reg >> 1;

    // 2-of-3 vote over the samples taken around mid-bit; these are stable
    // from edge P/2+1 onward, so using them at the wrap is safe.
    assign majority  = (samples_reg[0] & samples_reg[1]) |
                       (samples_reg[0] & samples_reg[2]) |
                       (samples_reg[1] & samples_reg[2]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!RX_IN) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (wrap) begin
                    state_next = majority ? IDLE : DATA;
                end
            end
            DATA: begin
                if (wrap && last_bit) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        shift_en        = 1'b0;
        par_chk         = 1'b0;
        data_valid_next = 1'b0;
        par_err_next    = 1'b0;
        stp_err_next    = 1'b0;
        case (state_reg)
            DATA:   shift_en = wrap;
            PARITY: par_chk  = wrap;
            STOP: begin
                if (wrap) begin
                    // Framing error outranks parity error.
                    stp_err_next    = !majority;
                    par_err_next    = majority && par_flag_reg;
                    data_valid_next = majority && !par_flag_reg;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Edge counter: 0..P-1 in every non-IDLE state.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            edge_cnt_reg <= start_det ? PRESCALE_WIDTH'(1) : '0;
        end else if (wrap) begin
            edge_cnt_reg <= '0;
        end else begin
            edge_cnt_reg <= edge_cnt_reg + PRESCALE_WIDTH'(1);
        end
    end

    // Configuration is frozen for the duration of a frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_reg <= '0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
        end else if (start_det) begin
            prescale_reg <= Prescale;
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
        end
    end

    // Bit counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_reg <= '0;
        end else if (start_det) begin
            bit_cnt_reg <= '0;
        end else if (shift_en) begin
            bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + BCW'(1);
        end
    end

    // Three mid-bit samples at edges P/2-2, P/2-1, P/2.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sample
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    samples_reg[gi] <= 1'b1;
                end else if ((state_reg != IDLE) &&
                             (edge_cnt_reg == half - PRESCALE_WIDTH'(2) + PRESCALE_WIDTH'(gi))) begin
                    samples_reg[gi] <= RX_IN;
                end
            end
        end
    endgenerate

    // Data bits land directly in their final position (LSB first on the line).
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    shift_reg[gi] <= 1'b0;
                end else if (shift_en && (bit_cnt_reg == BCW'(gi))) begin
                    shift_reg[gi] <= majority;
                end
            end
        end
    endgenerate

    // Parity mismatch flag, cleared at every new start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_flag_reg <= 1'b0;
        end else if (start_det) begin
            par_flag_reg <= 1'b0;
        end else if (par_chk) begin
            par_flag_reg <= (majority != ((^shift_reg) ^ par_typ_reg));
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
        end else begin
            data_valid_reg <= data_valid_next;
            par_err_reg    <= par_err_next;
            stp_err_reg    <= stp_err_next;
            if (data_valid_next) begin
                p_data_reg <= shift_reg;
            end
        end
    end

    assign P_DATA     = p_data_reg;
    assign data_valid = data_valid_reg;
    assign par_err    = par_err_reg;
    assign stp_err    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//   Directed bench for uart_rx_frame: drives complete serial frames on RX_IN
//   with a line model, records every output pulse with its cycle number,
//   and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_frame #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;

    // Pulse recorders (written only by the monitor)
    int   dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];
    int   pe_cyc_q[$];
    int   se_cyc_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(P_DATA);
        end
        if (par_err) pe_cyc_q.push_back(cyc);
        if (stp_err) se_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Call at a negedge; leaves the line at b for p cycles.
    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] data, input int p, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (with_par) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    int dv0, pe0, se0;

    task automatic snap();
        dv0 = dv_cyc_q.size();
        pe0 = pe_cyc_q.size();
        se0 = se_cyc_q.size();
    endtask

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_p_data",     32'(P_DATA),     32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_par_err",    32'(par_err),    32'h0);
        check("rst_stp_err",    32'(stp_err),    32'h0);
        RST = 1'b1;
        idle(4);

        // 1) P=8, no parity, 0xA5
        snap();
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1);
        idle(4);
        check("a5_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
        check("a5_latency",  32'(dv_cyc_q[$] - start_cyc), 32'd80);
        check("a5_data",     32'(dv_dat_q[$]), 32'hA5);
        check("a5_pe_count", 32'(pe_cyc_q.size() - pe0), 32'd0);
        check("a5_se_count", 32'(se_cyc_q.size() - se0), 32'd0);

        // 2) P=16, even parity, 0x3C (four ones -> parity 0)
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h3C, 16, 1, 1'b0, 1'b1);
        idle(4);
        check("3c_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
        check("3c_latency",  32'(dv_cyc_q[$] - start_cyc), 32'd176);
        check("3c_data",     32'(P_DATA), 32'h3C);
        // wrong parity bit
        snap();
        send_frame(8'h3C, 16, 1, 1'b1, 1'b1);
        idle(4);
        check("3c_bad_pe_count", 32'(pe_cyc_q.size() - pe0), 32'd1);
        check("3c_bad_pe_lat",   32'(pe_cyc_q[$] - start_cyc), 32'd176);
        check("3c_bad_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd0);
        check("3c_bad_hold",     32'(P_DATA), 32'h3C);

        // 3) P=32, odd parity, 0x01 (correct parity 0), stop forced low
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h01, 32, 1, 1'b0, 1'b0);
        idle(8);
        check("stp_se_count", 32'(se_cyc_q.size() - se0), 32'd1);
        check("stp_se_lat",   32'(se_cyc_q[$] - start_cyc), 32'd352);
        check("stp_pe_count", 32'(pe_cyc_q.size() - pe0), 32'd0);
        check("stp_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd0);
        check("stp_hold",     32'(P_DATA), 32'h3C);

        // 4) Glitch of 2 cycles at P=8, then a valid 0x5A
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        drive_bit(1'b0, 2);
        idle(20);
        check("glitch_dv", 32'(dv_cyc_q.size() - dv0), 32'd0);
        check("glitch_pe", 32'(pe_cyc_q.size() - pe0), 32'd0);
        check("glitch_se", 32'(se_cyc_q.size() - se0), 32'd0);
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1);
        idle(4);
        check("5a_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
        check("5a_data",     32'(P_DATA), 32'h5A);

        // 5) Back-to-back 0x11, 0x22 with no idle gap
        snap();
        send_frame(8'h11, 8, 0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 0, 1'b0, 1'b1);
        idle(4);
        check("b2b_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd2);
        if (dv_cyc_q.size() - dv0 == 2) begin
            check("b2b_gap",   32'(dv_cyc_q[dv0 + 1] - dv_cyc_q[dv0]), 32'd80);
            check("b2b_first", 32'(dv_dat_q[dv0]),     32'h11);
            check("b2b_second",32'(dv_dat_q[dv0 + 1]), 32'h22);
        end

        // 6) Prescale changed 8 -> 16 mid-frame
        snap();
        fork
            send_frame(8'h96, 8, 0, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge CLK);
                Prescale = 6'd16;
            end
        join
        idle(4);
        check("cfg_dv_count", 32'(dv_cyc_q.size() - dv0), 32'd1);
        check("cfg_data",     32'(P_DATA), 32'h96);
        Prescale = 6'd8;

        // 7) Reset mid-frame, then a normal frame
        snap();
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        RST = 1'b0;
        RX_IN = 1'b1;
        @(negedge CLK);
        check("mrst_p_data", 32'(P_DATA),     32'h0);
        check("mrst_dv",     32'(data_valid), 32'h0);
        check("mrst_pe",     32'(par_err),    32'h0);
        check("mrst_se",     32'(stp_err),    32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(100);
        check("mrst_no_pulse", 32'(dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size()
                                   - dv0 - pe0 - se0), 32'd0);
        snap();
        send_frame(8'h3B, 8, 0, 1'b0, 1'b1);
        idle(4);
        check("post_rst_dv",   32'(dv_cyc_q.size() - dv0), 32'd1);
        check("post_rst_data", 32'(P_DATA), 32'h3B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
